// File: rtl/pcie_tx_arbiter.sv
// Per-TLP arbiter merging the PIO completion stream (req/ack) and the
// Ethernet-injected TLP stream (plain AXI-Stream) onto pcie_tx1, followed by
// a 2-entry registered output slice.
module pcie_tx_arbiter #(
  parameter int    C_DATA_WIDTH = 64,
  parameter int    KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int    CNT_WIDTH    = 32,
  parameter string APP_PRIORITY = "FALSE"
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,
  input  logic                    app_tx_req,
  output logic                    app_tx_ack,
  output logic                    app_tx_tready,
  input  logic                    app_tx_tvalid,
  input  logic                    app_tx_tlast,
  input  logic [KEEP_WIDTH-1:0]   app_tx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] app_tx_tdata,
  input  logic [3:0]              app_tx_tuser,
  output logic                    eth_tx_tready,
  input  logic                    eth_tx_tvalid,
  input  logic                    eth_tx_tlast,
  input  logic [KEEP_WIDTH-1:0]   eth_tx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] eth_tx_tdata,
  input  logic [3:0]              eth_tx_tuser,
  input  logic                    pcie_tx1_tready,
  output logic                    pcie_tx1_tvalid,
  output logic                    pcie_tx1_tlast,
  output logic [KEEP_WIDTH-1:0]   pcie_tx1_tkeep,
  output logic [C_DATA_WIDTH-1:0] pcie_tx1_tdata,
  output logic [3:0]              pcie_tx1_tuser,
  output logic [CNT_WIDTH-1:0]    app_tlp_cnt,
  output logic [CNT_WIDTH-1:0]    eth_tlp_cnt
);

  localparam bit APP_PRIO = (APP_PRIORITY == "TRUE");

  typedef enum logic [1:0] {IDLE, GNT_APP, GNT_ETH} state_t;

  state_t state, state_nxt;
  logic   rr_last_eth;   // 1: Ethernet source held the most recent grant
  logic   started;       // a beat of the current TLP has been accepted
  logic   in_ready;
  logic   in_valid, in_fire, in_last;
  logic   app_last_fire, eth_last_fire;
  logic [KEEP_WIDTH-1:0]   in_keep;
  logic [C_DATA_WIDTH-1:0] in_data;
  logic [3:0]              in_user;

  logic                    out_valid, out_last;
  logic [KEEP_WIDTH-1:0]   out_keep;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic [3:0]              out_user;
  logic                    skid_valid, skid_last;
  logic [KEEP_WIDTH-1:0]   skid_keep;
  logic [C_DATA_WIDTH-1:0] skid_data;
  logic [3:0]              skid_user;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;

  // Grant state, round-robin history and TLP-started flag
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state       <= IDLE;
      rr_last_eth <= 1'b1;
      started     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT_APP) rr_last_eth <= 1'b0;
      else if (state == IDLE && state_nxt == GNT_ETH) rr_last_eth <= 1'b1;
      if (state == IDLE) started <= 1'b0;
      else if (in_fire) started <= 1'b1;
    end
  end

  // Arbitration, grant-time handshakes and input mux to the output slice
  always_comb begin
    state_nxt     = state;
    app_tx_ack    = 1'b0;
    app_tx_tready = 1'b0;
    eth_tx_tready = 1'b0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_keep       = '0;
    in_data       = '0;
    in_user       = '0;
    app_last_fire = 1'b0;
    eth_last_fire = 1'b0;
    case (state)
      IDLE: begin
        if (app_tx_req && eth_tx_tvalid)
          state_nxt = (APP_PRIO || rr_last_eth) ? GNT_APP : GNT_ETH;
        else if (app_tx_req)
          state_nxt = GNT_APP;
        else if (eth_tx_tvalid)
          state_nxt = GNT_ETH;
      end
      GNT_APP: begin
        app_tx_ack    = 1'b1;
        app_tx_tready = in_ready;
        in_valid      = app_tx_tvalid;
        in_last       = app_tx_tlast;
        in_keep       = app_tx_tkeep;
        in_data       = app_tx_tdata;
        in_user       = app_tx_tuser;
        app_last_fire = app_tx_tvalid & in_ready & app_tx_tlast;
        // A withdrawn request only releases the grant before any beat moved
        if (app_last_fire)
          state_nxt = IDLE;
        else if (!started && !(app_tx_tvalid && in_ready) && !app_tx_req)
          state_nxt = IDLE;
      end
      GNT_ETH: begin
        eth_tx_tready = in_ready;
        in_valid      = eth_tx_tvalid;
        in_last       = eth_tx_tlast;
        in_keep       = eth_tx_tkeep;
        in_data       = eth_tx_tdata;
        in_user       = eth_tx_tuser;
        eth_last_fire = eth_tx_tvalid & in_ready & eth_tx_tlast;
        if (eth_last_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-source TLP counters, wrapping naturally
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      app_tlp_cnt <= '0;
      eth_tlp_cnt <= '0;
    end else begin
      if (app_last_fire) app_tlp_cnt <= app_tlp_cnt + CNT_WIDTH'(1);
      if (eth_last_fire) eth_tlp_cnt <= eth_tlp_cnt + CNT_WIDTH'(1);
    end
  end

  // Output register with skid entry; skid drains before new input is taken
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_keep   <= '0;
      out_data   <= '0;
      out_user   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_keep  <= '0;
      skid_data  <= '0;
      skid_user  <= '0;
    end else if (!skid_valid) begin
      if (in_fire) begin
        if (!out_valid || pcie_tx1_tready) begin
          out_valid <= 1'b1;
          out_last  <= in_last;
          out_keep  <= in_keep;
          out_data  <= in_data;
          out_user  <= in_user;
        end else begin
          skid_valid <= 1'b1;
          skid_last  <= in_last;
          skid_keep  <= in_keep;
          skid_data  <= in_data;
          skid_user  <= in_user;
        end
      end else if (pcie_tx1_tready) begin
        out_valid <= 1'b0;
      end
    end else if (pcie_tx1_tready) begin
      out_last   <= skid_last;
      out_keep   <= skid_keep;
      out_data   <= skid_data;
      out_user   <= skid_user;
      skid_valid <= 1'b0;
    end
  end

  assign pcie_tx1_tvalid = out_valid;
  assign pcie_tx1_tlast  = out_last;
  assign pcie_tx1_tkeep  = out_keep;
  assign pcie_tx1_tdata  = out_data;
  assign pcie_tx1_tuser  = out_user;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: round-robin and priority instances
// share stimulus; a cycle-stepped source model drives both input streams.
module tb_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 3;

  logic pcie_clk = 1'b0;
  logic pcie_rst_n = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  logic          app_tx_req = 1'b0, app_tx_tvalid = 1'b0, app_tx_tlast = 1'b0;
  logic [KW-1:0] app_tx_tkeep = '0;
  logic [DW-1:0] app_tx_tdata = '0;
  logic [3:0]    app_tx_tuser = '0;
  logic          eth_tx_tvalid = 1'b0, eth_tx_tlast = 1'b0;
  logic [KW-1:0] eth_tx_tkeep = '0;
  logic [DW-1:0] eth_tx_tdata = '0;
  logic [3:0]    eth_tx_tuser = '0;
  logic          pcie_tx1_tready = 1'b1;

  logic          d_ack, d_app_rdy, d_eth_rdy, d_tvalid, d_tlast;
  logic [KW-1:0] d_tkeep;
  logic [DW-1:0] d_tdata;
  logic [3:0]    d_tuser;
  logic [CW-1:0] d_app_cnt, d_eth_cnt;
  logic          p_ack, p_app_rdy, p_eth_rdy, p_tvalid, p_tlast;
  logic [KW-1:0] p_tkeep;
  logic [DW-1:0] p_tdata;
  logic [3:0]    p_tuser;
  logic [CW-1:0] p_app_cnt, p_eth_cnt;

  pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW), .APP_PRIORITY("FALSE")) u_dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
    .app_tx_req(app_tx_req), .app_tx_ack(d_ack), .app_tx_tready(d_app_rdy),
    .app_tx_tvalid(app_tx_tvalid), .app_tx_tlast(app_tx_tlast), .app_tx_tkeep(app_tx_tkeep),
    .app_tx_tdata(app_tx_tdata), .app_tx_tuser(app_tx_tuser),
    .eth_tx_tready(d_eth_rdy), .eth_tx_tvalid(eth_tx_tvalid), .eth_tx_tlast(eth_tx_tlast),
    .eth_tx_tkeep(eth_tx_tkeep), .eth_tx_tdata(eth_tx_tdata), .eth_tx_tuser(eth_tx_tuser),
    .pcie_tx1_tready(pcie_tx1_tready), .pcie_tx1_tvalid(d_tvalid), .pcie_tx1_tlast(d_tlast),
    .pcie_tx1_tkeep(d_tkeep), .pcie_tx1_tdata(d_tdata), .pcie_tx1_tuser(d_tuser),
    .app_tlp_cnt(d_app_cnt), .eth_tlp_cnt(d_eth_cnt)
  );

  pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW), .APP_PRIORITY("TRUE")) u_pri (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
    .app_tx_req(app_tx_req), .app_tx_ack(p_ack), .app_tx_tready(p_app_rdy),
    .app_tx_tvalid(app_tx_tvalid), .app_tx_tlast(app_tx_tlast), .app_tx_tkeep(app_tx_tkeep),
    .app_tx_tdata(app_tx_tdata), .app_tx_tuser(app_tx_tuser),
    .eth_tx_tready(p_eth_rdy), .eth_tx_tvalid(eth_tx_tvalid), .eth_tx_tlast(eth_tx_tlast),
    .eth_tx_tkeep(eth_tx_tkeep), .eth_tx_tdata(eth_tx_tdata), .eth_tx_tuser(eth_tx_tuser),
    .pcie_tx1_tready(pcie_tx1_tready), .pcie_tx1_tvalid(p_tvalid), .pcie_tx1_tlast(p_tlast),
    .pcie_tx1_tkeep(p_tkeep), .pcie_tx1_tdata(p_tdata), .pcie_tx1_tuser(p_tuser),
    .app_tlp_cnt(p_app_cnt), .eth_tlp_cnt(p_eth_cnt)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Source model: a_n/b_n TLPs queued, a_t/b_t sent, a_b/b_b beat within TLP
  int a_n = 0, a_t = 0, a_b = 0, a_len = 1;
  int b_n = 0, b_t = 0, b_b = 0, b_len = 1;
  bit a_nobeat = 1'b0;
  bit use_pri = 1'b0;
  logic [63:0] outq[$];

  function automatic logic [63:0] beat_word(input logic [3:0] src, input int t, input int b);
    return {src, 28'h0, t[15:0], b[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: at the falling edge drive sources, then account for the
  // handshakes that the next rising edge will perform.
  task automatic tick(input bit rdy);
    logic ack_s, ar, er, ov;
    logic [63:0] od;
    @(negedge pcie_clk);
    pcie_tx1_tready = rdy;
    ack_s = use_pri ? p_ack : d_ack;
    ar    = use_pri ? p_app_rdy : d_app_rdy;
    er    = use_pri ? p_eth_rdy : d_eth_rdy;
    ov    = use_pri ? p_tvalid : d_tvalid;
    od    = use_pri ? p_tdata : d_tdata;
    app_tx_req    = (a_t < a_n);
    app_tx_tvalid = app_tx_req && ack_s && !a_nobeat;
    app_tx_tlast  = (a_b == a_len - 1);
    app_tx_tkeep  = app_tx_tlast ? 8'h0F : 8'hFF;
    app_tx_tdata  = beat_word(4'hA, a_t, a_b);
    app_tx_tuser  = 4'h5;
    eth_tx_tvalid = (b_t < b_n);
    eth_tx_tlast  = (b_b == b_len - 1);
    eth_tx_tkeep  = 8'hFF;
    eth_tx_tdata  = beat_word(4'hB, b_t, b_b);
    eth_tx_tuser  = 4'hA;
    if (ov && rdy) outq.push_back(od);
    if (app_tx_tvalid && ar) begin
      if (app_tx_tlast) begin a_t++; a_b = 0; end else a_b++;
    end
    if (eth_tx_tvalid && er) begin
      if (eth_tx_tlast) begin b_t++; b_b = 0; end else b_b++;
    end
  endtask

  task automatic clear_model();
    a_n = 0; a_t = 0; a_b = 0; b_n = 0; b_t = 0; b_b = 0;
    a_nobeat = 1'b0;
    outq.delete();
  endtask

  task automatic do_reset();
    pcie_rst_n = 1'b0;
    clear_model();
    tick(1);
    tick(1);
    pcie_rst_n = 1'b1;
  endtask

  task automatic run(input int budget, input string tag);
    int c = 0;
    while ((a_t < a_n || b_t < b_n) && c < budget) begin
      tick(1);
      c++;
    end
    chk({tag, "_done"}, 64'(a_t >= a_n && b_t >= b_n), 64'd1);
    repeat (3) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------- reset state and single 3-beat A TLP ----------
    do_reset();
    chk("rst_tvalid", 64'(d_tvalid), 64'd0);
    chk("rst_ack", 64'(d_ack), 64'd0);
    chk("rst_tdata", d_tdata, 64'd0);
    chk("rst_cnts", 64'({d_app_cnt, d_eth_cnt}), 64'd0);
    chk("rst_readys", 64'({d_app_rdy, d_eth_rdy}), 64'd0);
    a_n = 1; a_len = 3;
    tick(1);
    chk("t1_ack_c0", 64'(d_ack), 64'd0);
    tick(1);
    chk("t1_ack_c1", 64'(d_ack), 64'd1);
    chk("t1_tvalid_c1", 64'(d_tvalid), 64'd0);
    tick(1);
    chk("t1_beat0", {63'd0, d_tvalid}, 64'd1);
    chk("t1_data0", d_tdata, beat_word(4'hA, 0, 0));
    tick(1);
    chk("t1_data1", d_tdata, beat_word(4'hA, 0, 1));
    chk("t1_ack_c3", 64'(d_ack), 64'd1);
    tick(1);
    chk("t1_data2", d_tdata, beat_word(4'hA, 0, 2));
    chk("t1_last", 64'(d_tlast), 64'd1);
    chk("t1_keep", 64'(d_tkeep), 64'h0F);
    chk("t1_user", 64'(d_tuser), 64'h5);
    chk("t1_ack_drop", 64'(d_ack), 64'd0);
    chk("t1_cnt", 64'(d_app_cnt), 64'd1);
    tick(1);
    chk("t1_idle_out", 64'(d_tvalid), 64'd0);

    // ---------- round robin, 4 TLPs each ----------
    do_reset();
    a_n = 4; a_len = 2; b_n = 4; b_len = 2;
    run(200, "rr");
    chk("rr_size", 64'(outq.size()), 64'd16);
    for (int p = 0; p < 16; p++) begin
      if (p < outq.size())
        chk("rr_order", outq[p], beat_word(((p % 4) < 2) ? 4'hA : 4'hB, p / 4, p % 2));
    end
    chk("rr_app_cnt", 64'(d_app_cnt), 64'd4);
    chk("rr_eth_cnt", 64'(d_eth_cnt), 64'd4);

    // ---------- strict priority instance ----------
    do_reset();
    use_pri = 1'b1;
    a_n = 6; a_len = 1; b_n = 1; b_len = 1;
    run(200, "pri");
    chk("pri_size", 64'(outq.size()), 64'd7);
    for (int p = 0; p < 7; p++) begin
      if (p < outq.size())
        chk("pri_order", outq[p], (p < 6) ? beat_word(4'hA, p, 0) : beat_word(4'hB, 0, 0));
    end
    chk("pri_app_cnt", 64'(p_app_cnt), 64'd6);
    chk("pri_eth_cnt", 64'(p_eth_cnt), 64'd1);
    use_pri = 1'b0;

    // ---------- core stalls 1,0,0,1 during a 4-beat B TLP ----------
    do_reset();
    b_n = 1; b_len = 4;
    tick(1);
    tick(1);
    chk("st_eth_rdy_c1", 64'(d_eth_rdy), 64'd1);
    tick(1);
    chk("st_data0", d_tdata, beat_word(4'hB, 0, 0));
    tick(0);
    chk("st_data1", d_tdata, beat_word(4'hB, 0, 1));
    chk("st_eth_rdy_c3", 64'(d_eth_rdy), 64'd1);
    tick(0);
    chk("st_hold_a", d_tdata, beat_word(4'hB, 0, 1));
    chk("st_hold_v", 64'(d_tvalid), 64'd1);
    chk("st_eth_rdy_drop", 64'(d_eth_rdy), 64'd0);
    tick(1);
    chk("st_hold_b", d_tdata, beat_word(4'hB, 0, 1));
    tick(1);
    chk("st_data2", d_tdata, beat_word(4'hB, 0, 2));
    tick(1);
    chk("st_data3", d_tdata, beat_word(4'hB, 0, 3));
    chk("st_last3", 64'(d_tlast), 64'd1);
    tick(1);
    chk("st_idle", 64'(d_tvalid), 64'd0);
    chk("st_size", 64'(outq.size()), 64'd4);
    for (int p = 0; p < 4; p++) begin
      if (p < outq.size()) chk("st_order", outq[p], beat_word(4'hB, 0, p));
    end
    chk("st_eth_cnt", 64'(d_eth_cnt), 64'd1);

    // ---------- A withdraws request after ack, no beats ----------
    do_reset();
    a_n = 1; a_len = 1; a_nobeat = 1'b1; b_n = 1; b_len = 1;
    tick(1);
    tick(1);
    chk("wd_ack", 64'(d_ack), 64'd1);
    chk("wd_eth_rdy_c1", 64'(d_eth_rdy), 64'd0);
    a_n = 0;
    tick(1);
    tick(1);
    chk("wd_ack_drop", 64'(d_ack), 64'd0);
    chk("wd_no_out", 64'(d_tvalid), 64'd0);
    chk("wd_idle_rdy", 64'({d_app_rdy, d_eth_rdy}), 64'd0);
    tick(1);
    chk("wd_eth_grant", 64'(d_eth_rdy), 64'd1);
    tick(1);
    tick(1);
    chk("wd_app_cnt", 64'(d_app_cnt), 64'd0);
    chk("wd_eth_cnt", 64'(d_eth_cnt), 64'd1);
    chk("wd_size", 64'(outq.size()), 64'd1);
    if (outq.size() > 0) chk("wd_beat", outq[0], beat_word(4'hB, 0, 0));
    a_nobeat = 1'b0;

    // ---------- reset mid-TLP, then recovery ----------
    do_reset();
    a_n = 1; a_len = 2;
    run(50, "rs_pre");
    chk("rs_pre_cnt", 64'(d_app_cnt), 64'd1);
    a_n = 2; a_len = 4;
    tick(1);
    tick(1);
    tick(1);
    chk("rs_mid_valid", 64'(d_tvalid), 64'd1);
    #2 pcie_rst_n = 1'b0;
    #1;
    chk("rs_tvalid", 64'(d_tvalid), 64'd0);
    chk("rs_ack", 64'(d_ack), 64'd0);
    chk("rs_app_cnt", 64'(d_app_cnt), 64'd0);
    chk("rs_app_rdy", 64'(d_app_rdy), 64'd0);
    clear_model();
    tick(1);
    pcie_rst_n = 1'b1;
    a_n = 1; a_len = 2;
    run(50, "rs_post");
    chk("rs_post_cnt", 64'(d_app_cnt), 64'd1);
    chk("rs_post_size", 64'(outq.size()), 64'd2);
    for (int p = 0; p < 2; p++) begin
      if (p < outq.size()) chk("rs_post_order", outq[p], beat_word(4'hA, 0, p));
    end

    // ---------- counter wrap at 2^CNT_WIDTH ----------
    a_n = 7; a_len = 1;
    run(200, "wr_fill");
    chk("wr_max", 64'(d_app_cnt), 64'd7);
    a_n = 8;
    run(50, "wr_wrap");
    chk("wr_zero", 64'(d_app_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
